// File: rtl/ct_clk_gate_ctrl.sv
// ct_clk_gate_ctrl
//   Per-domain clock-gating controller. Each of CH_NUM domains has its own
//   wake OR, programmable idle hysteresis and a sleep request/acknowledge
//   handshake before its clock enable is dropped.
//
// Ports
//   forever_coreclk  free-running core clock
//   cpurst           asynchronous active-high reset
//   wake_src         per-domain wake sources, channel i = [i*SRC_NUM +: SRC_NUM]
//   hyst_cfg         per-domain idle cycles before sleep request
//   force_on         per-domain keep-alive
//   global_gate_dis  disables gating of every domain
//   sleep_ack        domain quiesced, safe to gate (only honoured in SREQ)
//   sleep_req        request domain to quiesce (registered)
//   clk_en           ICG enable per domain (registered)
//   ch_state         per-domain state: RUN=00 IDLE=01 SREQ=10 OFF=11
//
// Optional feature (macro CT_CLK_GATE_STAT_EN)
//   stat_clr         clears all gated-cycle counters
//   gated_cnt        per-domain saturating 16-bit count of cycles spent in OFF

module ct_clk_gate_ctrl #(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned SRC_NUM = 7,
  parameter int unsigned HYST_W  = 4
) (
  input  logic                        forever_coreclk,
  input  logic                        cpurst,
  input  logic [CH_NUM*SRC_NUM-1:0]   wake_src,
  input  logic [CH_NUM*HYST_W-1:0]    hyst_cfg,
  input  logic [CH_NUM-1:0]           force_on,
  input  logic                        global_gate_dis,
  input  logic [CH_NUM-1:0]           sleep_ack,
`ifdef CT_CLK_GATE_STAT_EN
  input  logic                        stat_clr,
  output logic [CH_NUM*16-1:0]        gated_cnt,
`endif
  output logic [CH_NUM-1:0]           sleep_req,
  output logic [CH_NUM-1:0]           clk_en,
  output logic [CH_NUM*2-1:0]         ch_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_IDLE = 2'b01,
    ST_SREQ = 2'b10,
    ST_OFF  = 2'b11
  } ch_state_e;

  ch_state_e         state_q [CH_NUM];
  ch_state_e         state_d [CH_NUM];
  logic [HYST_W-1:0] cnt_q   [CH_NUM];
  logic [HYST_W-1:0] cnt_d   [CH_NUM];
  logic [CH_NUM-1:0] wake;
  logic [CH_NUM-1:0] clk_en_q;
  logic [CH_NUM-1:0] clk_en_d;
  logic [CH_NUM-1:0] sleep_req_q;
  logic [CH_NUM-1:0] sleep_req_d;

  // global_gate_dis folds into every channel's wake, so it both aborts any
  // sleep sequence and holds the channel in RUN while asserted.
  always_comb begin
    wake = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      wake[ch] = (|wake_src[ch*SRC_NUM +: SRC_NUM]) | force_on[ch] | global_gate_dis;
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        ST_RUN: begin
          if (!wake[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = hyst_cfg[ch*HYST_W +: HYST_W];
          end
        end
        ST_IDLE: begin
          if (wake[ch]) begin
            state_d[ch] = ST_RUN;
          end else if (cnt_q[ch] == '0) begin
            state_d[ch] = ST_SREQ;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 1'b1;
          end
        end
        ST_SREQ: begin
          // Wake has priority over a same-cycle acknowledge.
          if (wake[ch]) begin
            state_d[ch] = ST_RUN;
          end else if (sleep_ack[ch]) begin
            state_d[ch] = ST_OFF;
          end
        end
        ST_OFF: begin
          if (wake[ch]) begin
            state_d[ch] = ST_RUN;
          end
        end
        default: begin
          state_d[ch] = ST_RUN;
        end
      endcase
    end
  end

  // Outputs are registered from the next state, so they change on the same
  // edge as the state and have no combinational path from the inputs.
  always_comb begin
    clk_en_d    = '0;
    sleep_req_d = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      clk_en_d[ch]    = (state_d[ch] != ST_OFF);
      sleep_req_d[ch] = (state_d[ch] == ST_SREQ);
    end
  end

  always_ff @(posedge forever_coreclk or posedge cpurst) begin
    if (cpurst) begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        state_q[ch] <= ST_RUN;
        cnt_q[ch]   <= '0;
      end
      clk_en_q    <= '1;
      sleep_req_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      clk_en_q    <= clk_en_d;
      sleep_req_q <= sleep_req_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign sleep_req = sleep_req_q;

  always_comb begin
    ch_state = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      ch_state[ch*2 +: 2] = state_q[ch];
    end
  end

`ifdef CT_CLK_GATE_STAT_EN
  logic [15:0] gcnt_q [CH_NUM];
  logic [15:0] gcnt_d [CH_NUM];

  always_comb begin
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      gcnt_d[ch] = gcnt_q[ch];
      if (stat_clr) begin
        gcnt_d[ch] = '0;
      end else if ((state_q[ch] == ST_OFF) && (gcnt_q[ch] != '1)) begin
        gcnt_d[ch] = gcnt_q[ch] + 16'd1;
      end
    end
  end

  always_ff @(posedge forever_coreclk or posedge cpurst) begin
    if (cpurst) begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        gcnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
        gcnt_q[ch] <= gcnt_d[ch];
      end
    end
  end

  always_comb begin
    gated_cnt = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      gated_cnt[ch*16 +: 16] = gcnt_q[ch];
    end
  end
`endif

endmodule

// File: tb/tb_ct_clk_gate_ctrl.sv
module tb_ct_clk_gate_ctrl;

  localparam int unsigned CH  = 4;
  localparam int unsigned SRC = 7;
  localparam int unsigned HW  = 4;

  logic              clk;
  logic              rst;
  logic [CH*SRC-1:0] wake_src;
  logic [CH*HW-1:0]  hyst_cfg;
  logic [CH-1:0]     force_on;
  logic              gdis;
  logic [CH-1:0]     sleep_ack;
  logic [CH-1:0]     sleep_req;
  logic [CH-1:0]     clk_en;
  logic [CH*2-1:0]   ch_state;
`ifdef CT_CLK_GATE_STAT_EN
  logic              stat_clr;
  logic [CH*16-1:0]  gated_cnt;
`endif

  int errors = 0;
  int checks = 0;

  ct_clk_gate_ctrl #(.CH_NUM(CH), .SRC_NUM(SRC), .HYST_W(HW)) dut (
    .forever_coreclk (clk),
    .cpurst          (rst),
    .wake_src        (wake_src),
    .hyst_cfg        (hyst_cfg),
    .force_on        (force_on),
    .global_gate_dis (gdis),
    .sleep_ack       (sleep_ack),
`ifdef CT_CLK_GATE_STAT_EN
    .stat_clr        (stat_clr),
    .gated_cnt       (gated_cnt),
`endif
    .sleep_req       (sleep_req),
    .clk_en          (clk_en),
    .ch_state        (ch_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wake_src = '0; force_on = '0; gdis = 1'b0;
    hyst_cfg = {4{4'd3}}; sleep_ack = '1;
    tick(); tick();
    checks++; if (clk_en !== 4'hF) begin errors++; $display("FAIL rst_clk_en got=%h exp=f", clk_en); end
    checks++; if (ch_state !== 8'h00) begin errors++; $display("FAIL rst_state got=%h exp=00", ch_state); end
    checks++; if (sleep_req !== 4'h0) begin errors++; $display("FAIL rst_sleep_req got=%h exp=0", sleep_req); end
    rst = 1'b0;
    tick();
    checks++; if (ch_state !== 8'h55) begin errors++; $display("FAIL first_idle got=%h exp=55", ch_state); end
    tick(); tick(); tick();
    checks++; if (sleep_req !== 4'h0 || ch_state !== 8'h55) begin errors++; $display("FAIL hyst_early req=%h st=%h exp req=0 st=55", sleep_req, ch_state); end
    tick();
    checks++; if (sleep_req !== 4'hF || ch_state !== 8'hAA) begin errors++; $display("FAIL sreq_at_5 req=%h st=%h exp req=f st=aa", sleep_req, ch_state); end
    tick();
    checks++; if (clk_en !== 4'h0 || ch_state !== 8'hFF || sleep_req !== 4'h0) begin errors++; $display("FAIL off_entry en=%h st=%h req=%h exp en=0 st=ff req=0", clk_en, ch_state, sleep_req); end
  endtask

  task automatic test_idle_abort();
    force_on = '1; sleep_ack = '0;
    tick();
    checks++; if (clk_en !== 4'hF || ch_state !== 8'h00) begin errors++; $display("FAIL force_wake en=%h st=%h exp en=f st=00", clk_en, ch_state); end
    force_on = 4'b1110;
    tick(); tick();
    checks++; if (ch_state[1:0] !== 2'b01) begin errors++; $display("FAIL ch0_idle got=%b exp=01", ch_state[1:0]); end
    wake_src[0] = 1'b1;
    tick();
    wake_src[0] = 1'b0;
    checks++; if (ch_state[1:0] !== 2'b00 || sleep_req[0] !== 1'b0) begin errors++; $display("FAIL idle_abort st=%b req=%b exp st=00 req=0", ch_state[1:0], sleep_req[0]); end
    tick();
    // Counter reloaded with 3; a later hyst_cfg change must be ignored.
    hyst_cfg[3:0] = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ch_state[1:0] !== 2'b01 || sleep_req[0] !== 1'b0) begin errors++; $display("FAIL reload_idle%0d st=%b req=%b exp st=01 req=0", i, ch_state[1:0], sleep_req[0]); end
    end
    tick();
    checks++; if (ch_state[1:0] !== 2'b10 || sleep_req[0] !== 1'b1) begin errors++; $display("FAIL reload_sreq st=%b req=%b exp st=10 req=1", ch_state[1:0], sleep_req[0]); end
    checks++; if (ch_state[7:2] !== 6'b000000) begin errors++; $display("FAIL others_run got=%b exp=000000", ch_state[7:2]); end
  endtask

  task automatic test_sreq_abort();
    sleep_ack[0] = 1'b1; force_on[0] = 1'b1;
    tick();
    checks++; if (ch_state[1:0] !== 2'b00 || clk_en[0] !== 1'b1 || sleep_req[0] !== 1'b0) begin errors++; $display("FAIL sreq_abort st=%b en=%b req=%b exp st=00 en=1 req=0", ch_state[1:0], clk_en[0], sleep_req[0]); end
    sleep_ack = '0;
  endtask

  task automatic test_off_wake();
    hyst_cfg = '0; force_on = 4'b1001; sleep_ack = 4'b0110;
    tick();
    checks++; if (ch_state !== 8'h14) begin errors++; $display("FAIL h0_idle got=%h exp=14", ch_state); end
    tick(); tick();
    checks++; if (clk_en !== 4'b1001 || ch_state !== 8'h3C) begin errors++; $display("FAIL two_off en=%b st=%h exp en=1001 st=3c", clk_en, ch_state); end
    wake_src[2*SRC] = 1'b1;
    #1;
    checks++; if (clk_en[2] !== 1'b0) begin errors++; $display("FAIL comb_path en2=%b exp=0", clk_en[2]); end
    tick();
    checks++; if (clk_en !== 4'b1101 || ch_state !== 8'h0C) begin errors++; $display("FAIL off_wake en=%b st=%h exp en=1101 st=0c", clk_en, ch_state); end
    wake_src = '0;
  endtask

  task automatic test_global();
    force_on = '0; sleep_ack = '1;
    tick(); tick(); tick();
    checks++; if (clk_en !== 4'h0 || ch_state !== 8'hFF) begin errors++; $display("FAIL all_off en=%h st=%h exp en=0 st=ff", clk_en, ch_state); end
    gdis = 1'b1;
    tick();
    checks++; if (clk_en !== 4'hF || ch_state !== 8'h00) begin errors++; $display("FAIL gdis_wake en=%h st=%h exp en=f st=00", clk_en, ch_state); end
    for (int i = 0; i < 4; i++) begin
      sleep_ack = (i % 2 == 0) ? 4'h0 : 4'hF;
      tick();
      checks++; if (ch_state !== 8'h00 || sleep_req !== 4'h0 || clk_en !== 4'hF) begin errors++; $display("FAIL gdis_hold%0d st=%h req=%h en=%h exp st=00 req=0 en=f", i, ch_state, sleep_req, clk_en); end
    end
    gdis = 1'b0; sleep_ack = '0;
    tick();
    checks++; if (ch_state !== 8'h55) begin errors++; $display("FAIL h0_one_idle got=%h exp=55", ch_state); end
    tick();
    checks++; if (ch_state !== 8'hAA || sleep_req !== 4'hF || clk_en !== 4'hF) begin errors++; $display("FAIL h0_sreq st=%h req=%h en=%h exp st=aa req=f en=f", ch_state, sleep_req, clk_en); end
    tick();
    checks++; if (ch_state !== 8'hAA) begin errors++; $display("FAIL sreq_wait got=%h exp=aa", ch_state); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    checks++; if (ch_state !== 8'h00 || sleep_req !== 4'h0 || clk_en !== 4'hF) begin errors++; $display("FAIL async_rst st=%h req=%h en=%h exp st=00 req=0 en=f", ch_state, sleep_req, clk_en); end
    tick();
    rst = 1'b0;
  endtask

`ifdef CT_CLK_GATE_STAT_EN
  task automatic test_stat();
    sleep_ack = '1;
    tick(); tick(); tick();
    checks++; if (ch_state !== 8'hFF || gated_cnt !== 64'h0) begin errors++; $display("FAIL stat_start st=%h cnt=%h exp st=ff cnt=0", ch_state, gated_cnt); end
    tick(); tick(); tick();
    checks++; if (gated_cnt !== {4{16'd3}}) begin errors++; $display("FAIL stat_three got=%h exp=0003x4", gated_cnt); end
    repeat (70000) tick();
    checks++; if (gated_cnt !== {4{16'hFFFF}}) begin errors++; $display("FAIL stat_sat got=%h exp=ffffx4", gated_cnt); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++; if (gated_cnt !== 64'h0) begin errors++; $display("FAIL stat_clr got=%h exp=0", gated_cnt); end
    tick();
    checks++; if (gated_cnt !== {4{16'd1}}) begin errors++; $display("FAIL stat_one got=%h exp=0001x4", gated_cnt); end
    tick();
    checks++; if (gated_cnt !== {4{16'd2}}) begin errors++; $display("FAIL stat_two got=%h exp=0002x4", gated_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (gated_cnt !== 64'h0 || clk_en !== 4'hF) begin errors++; $display("FAIL stat_rst cnt=%h en=%h exp cnt=0 en=f", gated_cnt, clk_en); end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
`ifdef CT_CLK_GATE_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_idle_abort();
    test_sreq_abort();
    test_off_wake();
    test_global();
    test_async_reset();
`ifdef CT_CLK_GATE_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
